// File: rtl/sort_dma_pkg.sv
// Shared types and constants for the sort accelerator's read-side DMA stage.
package sort_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } dma_state_e;

    localparam int WORD_BYTES       = 8;
    localparam int WORDS_PER_RECORD = 2;
    localparam int DEFAULT_ADDR_W   = 32;
    localparam int DEFAULT_LEN_W    = 19;

endpackage

// File: rtl/sort_rd_buf.sv
// In-order word buffer feeding the accelerator; the head word is kept in a
// register so odata/rdy come straight from flops.
module sort_rd_buf #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic                     not_empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d, kept;
    logic [DATA_W-1:0] head_q, head_d;
    logic              wr_acc, pop_acc;

    always_comb begin
        pop_acc  = pop && (count_q != '0);
        wr_acc   = wr_en && ((count_q != CW'(DEPTH)) || pop_acc);
        kept     = count_q - CW'(pop_acc);
        count_d  = kept + CW'(wr_acc);
        rd_ptr_d = rd_ptr_q + PW'(pop_acc);
        wr_ptr_d = wr_ptr_q + PW'(wr_acc);
        // Words surviving the pop take priority; an empty buffer takes the
        // incoming word directly so it is visible one cycle after arrival.
        head_d   = head_q;
        if (kept != '0) begin
            head_d = mem_q[rd_ptr_d];
        end else if (wr_acc) begin
            head_d = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign head      = head_q;
    assign not_empty = (count_q != '0);
    assign full      = (count_q == CW'(DEPTH));
    assign count     = count_q;

endmodule

// File: rtl/sort_rd_dma.sv
// Read-side DMA: fetches 2*num_records words in order, credit-limited so that
// every granted request always has a free buffer slot waiting for its data.
module sort_rd_dma
    import sort_dma_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = 64,
    parameter int LEN_W  = DEFAULT_LEN_W,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  num_records,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] odata,
    output logic              rdy,
    input  logic              pop,
    output logic              busy,
    output logic              done,
    output logic              ovf_err,
    output logic [1:0]        dbg_state
);
    localparam int CW   = $clog2(DEPTH) + 1;
    localparam int WL_W = LEN_W + 1;

    dma_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WL_W-1:0]   left_q, left_d;
    logic [CW-1:0]     out_q, out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;

    logic [CW-1:0]     buf_count, cnt_nxt;
    logic              buf_full;
    logic              credit_ok, gnt_acc, wr_acc, pop_acc;

    // Handshakes: a request transfers when mem_req && mem_gnt in the same
    // cycle; a consumer word transfers when rdy && pop in the same cycle.
    assign credit_ok = ({1'b0, out_q} + {1'b0, buf_count}) < (CW+1)'(DEPTH);
    assign mem_req   = (state_q == ST_REQ) && credit_ok;
    assign gnt_acc   = mem_req && mem_gnt;
    assign wr_acc    = mem_rvalid && !buf_full && (out_q != '0);
    assign pop_acc   = pop && rdy;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        left_d  = left_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q || (mem_rvalid && !wr_acc);
        out_d   = out_q + CW'(gnt_acc) - CW'(wr_acc);
        cnt_nxt = buf_count + CW'(wr_acc) - CW'(pop_acc);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d = base_addr;
                    left_d = WL_W'(num_records) * WL_W'(WORDS_PER_RECORD);
                    if (num_records == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_REQ;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (gnt_acc) begin
                    addr_d = addr_q + ADDR_W'(WORD_BYTES);
                    left_d = left_q - WL_W'(1);
                    if (left_q == WL_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Look at next-cycle occupancy so done lands right after the last pop.
                if (out_d == '0 && cnt_nxt == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            left_q  <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            left_q  <= left_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    sort_rd_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (reset),
        .wr_en     (wr_acc),
        .wr_data   (mem_rdata),
        .pop       (pop),
        .head      (odata),
        .not_empty (rdy),
        .full      (buf_full),
        .count     (buf_count)
    );

    assign mem_addr  = addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ovf_err   = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: doc/sort_rd_dma.md
# sort_rd_dma

Read-side DMA stage that sits directly upstream of the sort/encrypt accelerator. It fetches 64-bit words for a contiguous run of 128-bit records from the memory bus and buffers them in a small in-order FIFO. It presents the words to the accelerator's `idata`/`rdy`/`pop` input port. Outstanding requests are credit-limited, so returned data can never overflow the buffer.

## Interface
Parameters:
- ADDR_W, 32, memory byte-address width
- DATA_W, 64, word width (fixed at 64; one record = 2 words)
- LEN_W, 19, record-count width (matches accelerator `index_width`)
- DEPTH, 8, buffer depth in words (power of 2, ≥2)

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; launches a transfer when idle
- base_addr  in  ADDR_W  byte address of first record; sampled on accepted start
- num_records  in  LEN_W  records to fetch; sampled on accepted start
- mem_req  out  1  read request valid
- mem_addr  out  ADDR_W  request byte address
- mem_gnt  in  1  request accepted this cycle (mem_req & mem_gnt)
- mem_rvalid  in  1  read data beat valid; responses return in request order
- mem_rdata  in  DATA_W  read data
- odata  out  DATA_W  head-of-buffer word (to accelerator `idata`)
- rdy  out  1  buffer non-empty (to accelerator `rdy`)
- pop  in  1  consumer removes head word (from accelerator `pop`)
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer end
- ovf_err  out  1  sticky: rvalid arrived with no credit

## Operation
- Reset values: mem_req=0, mem_addr=0, odata=0, rdy=0, busy=0, done=0, ovf_err=0. All counters and FIFO pointers are 0. The FSM is in IDLE.
- FSM states:
  - IDLE:
    - start → latch base_addr and words_left = 2·num_records (LEN_W+1 bits); busy=1.
    - num_records==0 → DONE; otherwise → REQ.
  - REQ: mem_req=1 whenever credit is available.
    - On each grant: mem_addr += 8 (modulo 2^ADDR_W, wraps silently), words_left−1, outstanding+1.
    - Last grant → DRAIN.
  - DRAIN: wait until outstanding==0 and the buffer is empty, then → DONE.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- Credit rule: mem_req asserts only when outstanding + fifo_count < DEPTH. A grant and an rvalid in the same cycle update outstanding by +1−1=0.
- Response handling:
  - Each mem_rvalid beat writes mem_rdata to the FIFO tail and decrements outstanding.
  - If the FIFO is full or outstanding==0 when rvalid arrives, the beat is dropped and ovf_err sets. ovf_err clears only on reset.
- Buffer behaviour:
  - odata shows the head word whenever rdy=1.
  - pop with rdy=1 advances the head. pop with rdy=0 is ignored.
  - A simultaneous write and pop is legal at any occupancy, including full (count unchanged) and empty-with-write (count becomes 1).
- start while busy=1 is ignored.
- Reset asserted mid-transfer aborts immediately. Beats returned after reset release are not expected; if one arrives, it is handled by the ovf_err rule.

## Timing
- Start accepted at cycle 0 → mem_req=1 at cycle 1, mem_addr=base_addr.
- Fully registered outputs:
  - rvalid at cycle N → rdy=1 and odata valid at cycle N+1.
  - pop at cycle N → next head or rdy=0 at cycle N+1.
- Throughput: one grant per cycle sustained while credit is available. One word per cycle to the consumer.
- done asserts the cycle after the last word is popped. With num_records==0, done asserts at cycle 1.
- mem_addr holds stable while mem_req=1 and mem_gnt=0.

## Structure
- Shared package `sort_dma_pkg`:
  - FSM state encoding (IDLE, REQ, DRAIN, DONE; 2-bit).
  - Constant WORD_BYTES=8 and WORDS_PER_RECORD=2.
  - Default widths ADDR_W/LEN_W.
- One sub-module `sort_rd_buf`: synchronous DEPTH×DATA_W FIFO with registered head, count output, and write/pop/full/empty. The top level contains the FSM, address/length counters and credit logic.

## Test plan
- Basic run: base_addr=0x1000, num_records=2, mem_gnt always 1, rvalid one cycle after grant.
  - Required: addresses 0x1000, 0x1008, 0x1010, 0x1018.
  - Four words appear in order on odata with pop held at 1.
  - done pulses once; busy=0 afterwards.
- Backpressure: DEPTH=8, num_records=8, pop=0 throughout. Required: exactly 8 grants, then mem_req=0 and rdy=1 holding the first word. Then pop=1 → the remaining 8 grants issue and all 16 words are delivered in order.
- Zero length: num_records=0. Required: done=1 at cycle 1, mem_req never asserts.
- Wrap and stall: base_addr=0xFFFFFFF8, num_records=1, mem_gnt low for 3 cycles. Required: mem_addr holds at 0xFFFFFFF8 during the stall, then the next request is 0x00000000.
- Protocol error: inject rvalid with outstanding==0. Required: ovf_err=1 and FIFO count unchanged. ovf_err stays 1 until reset.
- Reset mid-transfer: assert reset (low) after 3 grants. Required: all outputs return to reset values immediately. A new start after release behaves as in the basic run.
